mul16_seq: RTL and testbench

Sequential 16x16 multiplier controller that time-shares a single `add16_gate` instance as its only adder. It runs a shift-and-add over 16 clock cycles and returns the low 16 bits of the product. The low 16 bits are identical for signed and unsigned two's-complement operands. It sits beside the ALU as the multi-cycle multiply resource and uses a start/busy/done handshake.

---
 rtl/mul16_seq_if.sv | 20 ++
 rtl/mul16_seq.sv | 97 +++++++++
 tb/tb_mul16_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mul16_seq_if.sv
// Start/busy/done handshake bundle for mul16_seq; operands in, product and status out.
// The requester owns start/a/b; the multiplier owns out/busy/done.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  out, busy, done
  );

  modport slave (
    input  start, a, b,
    output out, busy, done
  );
endinterface

// File: rtl/mul16_seq.sv
// Shift-and-add 16x16 multiplier (low 16 product bits) sharing one ripple adder; 16 RUN cycles + 1 DONE.
// start is honoured only in IDLE (never queued); issue interval is 18 cycles.
module add16_gate (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic [15:0] c;

  assign c[0] = 1'b0;
  for (genvar i = 0; i < 15; i++) begin : g_carry
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  // Carry out of bit 15 is never formed: products are modulo 2^16.
  assign sum = a ^ b ^ c;
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  mul16_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic [15:0] add_sum;

  add16_gate u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = 16'h0000;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          cnt_d    = 4'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = mplier_q[0] ? add_sum : acc_q;
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 4'd1;
        // Last step publishes the freshly accumulated value, never a partial sum.
        if (cnt_q == 4'd15) begin
          out_d   = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      cnt_q    <= 4'd0;
      out_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_mul16_seq.sv
// Scenario bench for mul16_seq: expected products queued at issue, popped at each done pulse.
module tb_mul16_seq;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [15:0] sb[$];

  mul16_seq_if bus ();

  mul16_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = x * y;
    return p[15:0];
  endfunction

  // Drives one accepted start; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
  endtask

  task automatic wait_done(output int busy_cyc, output int lat, output logic [15:0] o,
                           output bit overlap, output bit seen);
    busy_cyc = 0; lat = -1; o = '0; overlap = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = k; o = bus.out; seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h5678;
    repeat (3) @(negedge clk);
    checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic;
    int bc, lat, nd; logic [15:0] o, e; bit ov, seen;
    sb.push_back(model(16'h0003, 16'h0005));
    issue(16'h0003, 16'h0005);
    wait_done(bc, lat, o, ov, seen);
    e = sb.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL basic_done_timeout seen=0 exp=1"); end
    checks++; if (bc != 16) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency got=%0d exp=16", lat); end
    checks++; if (o !== e || o !== 16'h000F) begin errors++; $display("FAIL basic_out got=%h exp=%h", o, e); end
    checks++; if (ov) begin errors++; $display("FAIL basic_busy_done_overlap got=1 exp=0"); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_after_done done=%b busy=%b exp=0 0", bus.done, bus.busy); end
    checks++; if (bus.out !== e) begin errors++; $display("FAIL basic_out_held got=%h exp=%h", bus.out, e); end
    nd = 0;
    repeat (20) begin @(negedge clk); if (bus.done) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL basic_extra_done got=%0d exp=0", nd); end
  endtask

  task automatic test_patterns;
    logic [15:0] xa[5] = '{16'hFFFF, 16'h0100, 16'hFFFD, 16'hFFFD, 16'hA5C3};
    logic [15:0] xb[5] = '{16'hFFFF, 16'h0100, 16'h0007, 16'h0000, 16'h3F1D};
    int bc, lat; logic [15:0] o, e; bit ov, seen;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(xa[i], xb[i]));
      issue(xa[i], xb[i]);
      wait_done(bc, lat, o, ov, seen);
      e = sb.pop_front();
      checks++; if (o !== e || !seen) begin errors++; $display("FAIL pattern%0d_out a=%h b=%h got=%h exp=%h", i, xa[i], xb[i], o, e); end
      checks++; if (lat != 16 || bc != 16) begin errors++; $display("FAIL pattern%0d_latency got=%0d/%0d exp=16/16", i, lat, bc); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int rise[$]; int nd, diff; bit prev, ov; logic [15:0] e;
    nd = 0; prev = 1'b0; ov = 1'b0;
    @(negedge clk);
    bus.a = 16'd2; bus.b = 16'd9; bus.start = 1'b1;
    sb.push_back(model(16'd2, 16'd9));
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.busy && bus.done) ov = 1'b1;
      if (bus.busy && !prev) begin
        rise.push_back(cyc);
        if (rise.size() == 1) begin
          bus.a = 16'd4; bus.b = 16'd4;
          sb.push_back(model(16'd4, 16'd4));
        end else begin
          bus.start = 1'b0;
          bus.a = 16'($urandom); bus.b = 16'($urandom);
        end
      end
      if (bus.done) begin
        nd++;
        e = sb.pop_front();
        checks++; if (bus.out !== e) begin errors++; $display("FAIL b2b_out%0d got=%h exp=%h", nd, bus.out, e); end
        if (nd == 2) break;
      end
      prev = bus.busy;
    end
    bus.start = 1'b0;
    diff = (rise.size() >= 2) ? rise[1] - rise[0] : -1;
    checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
    checks++; if (diff != 18) begin errors++; $display("FAIL b2b_interval got=%0d exp=18", diff); end
    checks++; if (ov) begin errors++; $display("FAIL b2b_busy_done_overlap got=1 exp=0"); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int bc, lat, nd, nb; logic [15:0] o, e; bit ov, seen;
    issue(16'h0003, 16'h0005);
    repeat (7) @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_state busy=%b done=%b exp=0 0", bus.busy, bus.done); end
    checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL abort_out got=%h exp=0000", bus.out); end
    reset = 1'b0; bus.start = 1'b0;
    nd = 0; nb = 0;
    repeat (25) begin @(negedge clk); if (bus.done) nd++; if (bus.busy) nb++; end
    checks++; if (nd != 0 || nb != 0) begin errors++; $display("FAIL abort_no_done done=%0d busy=%0d exp=0 0", nd, nb); end
    sb.push_back(model(16'd7, 16'd6));
    issue(16'd7, 16'd6);
    wait_done(bc, lat, o, ov, seen);
    e = sb.pop_front();
    checks++; if (o !== e || o !== 16'h002A || lat != 16) begin errors++; $display("FAIL abort_followup got=%h lat=%0d exp=%h lat=16", o, lat, e); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int bc, nd, dk; logic [15:0] o, e;
    bc = 0; nd = 0; dk = -1; o = '0;
    sb.push_back(model(16'h1234, 16'h0021));
    issue(16'h1234, 16'h0021);
    for (int k = 0; k < 40; k++) begin
      if (bus.busy) bc++;
      if (bus.done) begin nd++; dk = k; o = bus.out; end
      if (k == 5 || k == 16) begin bus.start = 1'b1; bus.a = 16'hBEEF; bus.b = 16'h0003; end
      if (k == 6 || k == 17) bus.start = 1'b0;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++; if (bc != 16) begin errors++; $display("FAIL swb_busy_cycles got=%0d exp=16", bc); end
    checks++; if (nd != 1 || dk != 16) begin errors++; $display("FAIL swb_done got=%0d at=%0d exp=1 at=16", nd, dk); end
    checks++; if (o !== e) begin errors++; $display("FAIL swb_out got=%h exp=%h", o, e); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_abort();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
